// File: rtl/bcd_seq_converter_if.sv
// bcd_seq_converter_if: start/operand/result bundle; carries blank only when BCD_BLANK_EN is defined
interface bcd_seq_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;
`endif
  modport master (
    output start, bin,
    input  busy, done, bcd
`ifdef BCD_BLANK_EN
    , blank
`endif
  );
  modport slave (
    input  start, bin,
    output busy, done, bcd
`ifdef BCD_BLANK_EN
    , blank
`endif
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential double-dabble binary-to-BCD, one shift per clock; BCD_BLANK_EN adds a leading-zero mask
module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic               clk,
  input logic               rst,
  bcd_seq_converter_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scr_q, scr_d, bcd_q, bcd_d, adj, res;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW+WIDTH-1:0] sh;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_n;
  logic              z;
`endif
  // one double-dabble step: add 3 to every digit >= 5, then shift {scratch,shift} left
  always_comb begin
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = scr_q[4*k +: 4] >= 4'd5 ? scr_q[4*k +: 4] + 4'd3 : scr_q[4*k +: 4];
    sh  = {adj, shift_q} << 1;
    res = sh[BW+WIDTH-1:WIDTH];
`ifdef BCD_BLANK_EN
    z       = 1'b1;
    blank_n = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z          = z & (res[4*k +: 4] == 4'd0);
      blank_n[k] = z;
    end
`endif
  end
  // next-state: IDLE and DONE both accept start (DONE gives back-to-back), CONV ignores it
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
`ifdef BCD_BLANK_EN
    blank_d = blank_q;
`endif
    if (state_q == CONV) begin
      shift_d = sh[WIDTH-1:0];
      scr_d   = res;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = DONE;
        bcd_d   = res;
`ifdef BCD_BLANK_EN
        blank_d = blank_n;
`endif
      end
    end else begin
      state_d = bus.start ? CONV : IDLE;
      if (bus.start) begin
        shift_d = bus.bin;
        scr_d   = '0;
        cnt_d   = '0;
      end
    end
  end
  // state and datapath registers, reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
`ifdef BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
`ifdef BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end
  assign bus.busy = state_q == CONV;
  assign bus.done = state_q == DONE;
  assign bus.bcd  = bcd_q;
`ifdef BCD_BLANK_EN
  assign bus.blank = blank_q;
`endif
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: directed checks of latency, results, back-to-back, ignored start and abort
module tb_bcd_seq_converter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bcd_seq_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();
  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_blank(input string tag, input logic [2:0] exp);
`ifdef BCD_BLANK_EN
    check(tag, 32'(bus.blank), 32'(exp));
`endif
  endtask
  task automatic convert(input logic [7:0] b, input logic [11:0] exp, input logic [2:0] exp_blank, input string tag);
    int n;
    n = 0;
    bus.start = 1'b1;
    bus.bin   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 8'hA5;
    while (bus.busy && n < 20) begin
      check({tag, "_nodone"}, 32'(bus.done), 32'd0);
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd8);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
    check_blank({tag, "_blank"}, exp_blank);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask
  initial begin
    int t1, t2, n, dones;
    logic [11:0] got;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'h000);
    check_blank("rst_blank", 3'b000);
    rst = 1'b0;
    @(negedge clk);
    convert(8'd255, 12'h255, 3'b000, "b255");
    repeat (10) @(negedge clk);
    check("b255_hold", 32'(bus.bcd), 32'h255);
    convert(8'd0, 12'h000, 3'b110, "b0");
    convert(8'd7, 12'h007, 3'b110, "b7");
    convert(8'd99, 12'h099, 3'b100, "b99");
    bus.start = 1'b1;
    bus.bin   = 8'd128;
    n = 0;
    while (!bus.done && n < 30) begin n++; @(negedge clk); end
    t1 = cyc;
    check("b2b_first_bcd", 32'(bus.bcd), 32'h128);
    bus.bin = 8'd64;
    @(negedge clk);
    check("b2b_reload_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 30) begin n++; @(negedge clk); end
    t2 = cyc;
    bus.start = 1'b0;
    check("b2b_second_done", 32'(bus.done), 32'd1);
    check("b2b_spacing", 32'(t2 - t1), 32'd9);
    check("b2b_second_bcd", 32'(bus.bcd), 32'h064);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      check("ign_excl", 32'(bus.busy & bus.done), 32'd0);
      if (bus.done) begin dones++; got = bus.bcd; end
      @(negedge clk);
    end
    check("ign_dones", 32'(dones), 32'd1);
    check("ign_bcd", 32'(got), 32'h200);
    check_blank("ign_blank", 3'b000);
    bus.start = 1'b1;
    bus.bin   = 8'd255;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_bcd", 32'(bus.bcd), 32'h000);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("abort_nodone", 32'(dones), 32'd0);
    check("abort_bcd_hold", 32'(bus.bcd), 32'h000);
    convert(8'd42, 12'h042, 3'b100, "b42");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
